grayscale_pipe: RTL

GRAYSCALE_PIPE -- requirements
Module: grayscale_pipe

---
 rtl/grayscale_pkg.sv | 15 +
 rtl/grayscale_pipe_fifo.sv | 62 ++++++
 rtl/grayscale_pipe.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/grayscale_pkg.sv
// grayscale_pkg: constants and types shared by the grayscale pipeline.
// Holds the luma weights, the luma shift and the conversion-mode enum.
package grayscale_pkg;

  typedef enum logic {
    MODE_AVG  = 1'b0,
    MODE_LUMA = 1'b1
  } mode_e;

  localparam int unsigned LUMA_WR    = 77;
  localparam int unsigned LUMA_WG    = 150;
  localparam int unsigned LUMA_WB    = 29;
  localparam int unsigned LUMA_SHIFT = 8;

endpackage

// File: rtl/grayscale_pipe_fifo.sv
// fifo: first-word-fall-through FIFO; dout shows the head while !empty.
// Ports: clock, reset (async low), wr_en/din/full, rd_en/dout/empty, count.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic                   full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wp_q;
  logic [AW-1:0]         rp_q;
  logic [AW:0]           cnt_q;
  logic [AW:0]           cnt_d;
  logic                  wr;
  logic                  rd;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign wr    = wr_en && !full;
  assign rd    = rd_en && !empty;
  assign count = cnt_q;

  // Head is forced to zero when empty so nothing stale leaks out.
  assign dout = empty ? '0 : mem_q[rp_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr, rd})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr) mem_q[wp_q] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + AW'(1);
      if (rd) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/grayscale_pipe.sv
// grayscale_pipe: RGB -> gray, input FIFO, 2-stage pipe, output FIFO.
// Ports: clock, reset, mode, in_wr_en/in_din/in_full,
//        out_rd_en/out_dout/out_empty, frame_done.
module grayscale_pipe
  import grayscale_pkg::*;
#(
  parameter int CH_WIDTH   = 8,
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  in_wr_en,
  input  logic [3*CH_WIDTH-1:0] in_din,
  output logic                  in_full,
  input  logic                  out_rd_en,
  output logic [CH_WIDTH-1:0]   out_dout,
  output logic                  out_empty,
  output logic                  frame_done
);

  localparam int C    = CH_WIDTH;
  localparam int AW   = CH_WIDTH + 9;
  localparam int FW   = $clog2(FIFO_DEPTH) + 1;
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [C-1:0]  GMAX = '1;
  localparam logic [PW-1:0] LAST = PW'(NPIX - 1);

  typedef struct packed {
    mode_e         mode;
    logic [AW-1:0] acc;
  } s1_t;

  logic [3*C-1:0] pix;
  logic           in_empty;
  logic           in_pop;
  logic [FW-1:0]  in_cnt_unused;
  logic           out_full_unused;
  logic [FW-1:0]  out_cnt;
  logic           out_wr;
  logic [FW:0]    occ;
  logic           advance;

  logic           s1_v_q;
  logic           s2_v_q;
  s1_t            s1_q;
  s1_t            s1_d;
  logic [C-1:0]   s2_q;
  logic [C-1:0]   gray;
  mode_e          mode_q;
  mode_e          mode_sel;
  logic [PW-1:0]  in_idx_q;
  logic [PW-1:0]  pix_cnt_q;
  logic           frame_done_q;

  logic [AW-1:0]  r_w;
  logic [AW-1:0]  g_w;
  logic [AW-1:0]  b_w;
  logic [C+1:0]   avg;
  logic [AW-1:0]  q_d;

  fifo #(
    .DATA_WIDTH (3*C),
    .DEPTH      (FIFO_DEPTH)
  ) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (in_wr_en),
    .din   (in_din),
    .full  (in_full),
    .rd_en (in_pop),
    .dout  (pix),
    .empty (in_empty),
    .count (in_cnt_unused)
  );

  fifo #(
    .DATA_WIDTH (C),
    .DEPTH      (FIFO_DEPTH)
  ) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (out_wr),
    .din   (s2_q),
    .full  (out_full_unused),
    .rd_en (out_rd_en),
    .dout  (out_dout),
    .empty (out_empty),
    .count (out_cnt)
  );

  // Reserve output space for everything in flight so the out FIFO
  // can never be full when S2 writes into it.
  assign occ = {1'b0, out_cnt} + (FW+1)'(s1_v_q)
             + (FW+1)'(s2_v_q);
  assign advance = (occ < (FW+1)'(FIFO_DEPTH));
  assign in_pop  = advance && !in_empty;
  assign out_wr  = advance && s2_v_q;

  assign r_w = AW'(pix[C-1:0]);
  assign g_w = AW'(pix[2*C-1:C]);
  assign b_w = AW'(pix[3*C-1:2*C]);

  // Frame's first pixel samples the live mode; the rest reuse it.
  assign mode_sel = (in_idx_q == '0) ? mode_e'(mode) : mode_q;

  always_comb begin
    s1_d.mode = mode_sel;
    if (mode_sel == MODE_LUMA) begin
      s1_d.acc = r_w * AW'(LUMA_WR)
               + g_w * AW'(LUMA_WG)
               + b_w * AW'(LUMA_WB);
    end else begin
      s1_d.acc = r_w + g_w + b_w;
    end
  end

  assign avg = s1_q.acc[C+1:0] / (C+2)'(3);

  always_comb begin
    if (s1_q.mode == MODE_LUMA) q_d = s1_q.acc >> LUMA_SHIFT;
    else                        q_d = AW'(avg);
    gray = (q_d > AW'(GMAX)) ? GMAX : q_d[C-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_v_q       <= 1'b0;
      s2_v_q       <= 1'b0;
      s1_q         <= '0;
      s2_q         <= '0;
      mode_q       <= MODE_AVG;
      in_idx_q     <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (advance) begin
        s1_v_q <= in_pop;
        s1_q   <= s1_d;
        s2_v_q <= s1_v_q;
        s2_q   <= gray;
      end
      if (in_pop) begin
        mode_q   <= mode_sel;
        in_idx_q <= (in_idx_q == LAST) ? '0
                                       : in_idx_q + PW'(1);
      end
      if (out_wr) begin
        pix_cnt_q <= (pix_cnt_q == LAST) ? '0
                                         : pix_cnt_q + PW'(1);
      end
      frame_done_q <= out_wr && (pix_cnt_q == LAST);
    end
  end

  assign frame_done = frame_done_q;

endmodule
